// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS main control unit.
//   - opcode constants (instr[31:26])
//   - ALUop codes driven to the ALU control
//   - FSM state encoding (also exported on the debug state port)
//   - datapath mux select constants
//   - helper to map an immediate opcode to its ALU operation
package mips_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // ALUop codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    // FSM states
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] MEM_ADDR  = 4'd3;
    localparam logic [3:0] MEM_READ  = 4'd4;
    localparam logic [3:0] MEM_WB    = 4'd5;
    localparam logic [3:0] MEM_WRITE = 4'd6;
    localparam logic [3:0] R_EXEC    = 4'd7;
    localparam logic [3:0] R_WB      = 4'd8;
    localparam logic [3:0] BRANCH    = 4'd9;
    localparam logic [3:0] JUMP      = 4'd10;
    localparam logic [3:0] I_EXEC    = 4'd11;
    localparam logic [3:0] I_WB      = 4'd12;
    localparam logic [3:0] ILLEGAL   = 4'd13;

    // aluSrcB selects
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // memToReg selects
    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    // regDest selects
    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    // pcSource selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        case (op)
            OP_ANDI: immAluOp = ALU_AND;
            OP_ORI:  immAluOp = ALU_OR;
            OP_SLTI: immAluOp = ALU_SLT;
            default: immAluOp = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctr.sv
// multi_cycle_ctr: multi-cycle MIPS main control FSM.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables.
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   opCode             instr[31:26] from the IR, latched in DECODE
//   memReady           memory finishes the current access this cycle
//   pcWrite..pcSource  datapath control (see mips_ctrl_pkg for encodings)
//   illegalOp          one-cycle pulse on an unsupported opcode
//   state              current FSM state, for debug
module multi_cycle_ctr
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_IMM    = 1'b1,
    parameter bit ENABLE_JAL    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       branchNe,
    output logic       iorD,
    output logic       irWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic [1:0] memToReg,
    output logic [1:0] regDest,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       extZero,
    output logic [2:0] ALUop,
    output logic [1:0] pcSource,
    output logic       illegalOp,
    output logic [3:0] state
);

    logic [3:0] stateReg;
    logic [3:0] stateNext;
    logic [5:0] opReg;
    logic       ready;

    assign ready = MEM_HANDSHAKE ? memReady : 1'b1;
    assign state = stateReg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
            opReg    <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == DECODE) begin
                opReg <= opCode;
            end
        end
    end

    always_comb begin
        stateNext   = stateReg;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        branchNe    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = MTR_ALUOUT;
        regDest     = RDST_RT;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_RT;
        extZero     = 1'b0;
        ALUop       = ALU_ADD;
        pcSource    = PCSRC_ALU;
        illegalOp   = 1'b0;

        case (stateReg)
            IDLE: stateNext = FETCH;
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                // IR/PC load only on the cycle the memory returns the word
                if (ready) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    stateNext = DECODE;
                end
            end
            DECODE: begin
                aluSrcB = SRCB_IMM_SH;
                // Branch target computed speculatively; next state from the live opcode
                case (opCode)
                    OP_RTYPE:                           stateNext = R_EXEC;
                    OP_LW, OP_SW:                       stateNext = MEM_ADDR;
                    OP_BEQ, OP_BNE:                     stateNext = BRANCH;
                    OP_J:                               stateNext = JUMP;
                    OP_JAL:                             stateNext = ENABLE_JAL ? JUMP : ILLEGAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  stateNext = ENABLE_IMM ? I_EXEC : ILLEGAL;
                    default:                            stateNext = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_IMM;
                stateNext = (opReg == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (ready) stateNext = MEM_WB;
            end
            MEM_WB: begin
                memToReg  = MTR_MDR;
                regDest   = RDST_RT;
                regWrite  = 1'b1;
                stateNext = FETCH;
            end
            MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (ready) stateNext = FETCH;
            end
            R_EXEC: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_RT;
                ALUop     = ALU_FUNCT;
                stateNext = R_WB;
            end
            R_WB: begin
                regDest   = RDST_RD;
                regWrite  = 1'b1;
                stateNext = FETCH;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                ALUop       = ALU_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
                branchNe    = (opReg == OP_BNE);
                stateNext   = FETCH;
            end
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
                if (opReg == OP_JAL) begin
                    regWrite = 1'b1;
                    regDest  = RDST_RA;
                    memToReg = MTR_PC;
                end
                stateNext = FETCH;
            end
            I_EXEC: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_IMM;
                ALUop     = immAluOp(opReg);
                extZero   = (opReg == OP_ANDI) || (opReg == OP_ORI);
                stateNext = I_WB;
            end
            I_WB: begin
                // ALU result must stay valid while it is written back
                ALUop     = immAluOp(opReg);
                extZero   = (opReg == OP_ANDI) || (opReg == OP_ORI);
                regDest   = RDST_RT;
                regWrite  = 1'b1;
                stateNext = FETCH;
            end
            ILLEGAL: begin
                illegalOp = 1'b1;
                stateNext = FETCH;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Self-checking bench for multi_cycle_ctr. Instance A uses default parameters, instance B has
// jal disabled. Expected output vectors are queued per cycle with the stimulus and compared at
// the falling edge.
module tb_multi_cycle_ctr;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       branchNe;
        logic       iorD;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic [1:0] memToReg;
        logic [1:0] regDest;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       extZero;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       illegalOp;
        logic [3:0] state;
    } ctl_t;

    logic       clk;
    logic       reset_n;
    logic [5:0] opCode;
    logic       memReady;

    logic       pcWriteA, pcWriteCondA, branchNeA, iorDA, irWriteA, memReadA, memWriteA;
    logic [1:0] memToRegA, regDestA, aluSrcBA, pcSourceA;
    logic       regWriteA, aluSrcAA, extZeroA, illegalOpA;
    logic [2:0] aluOpA;
    logic [3:0] stateA;

    logic       pcWriteB, pcWriteCondB, branchNeB, iorDB, irWriteB, memReadB, memWriteB;
    logic [1:0] memToRegB, regDestB, aluSrcBB, pcSourceB;
    logic       regWriteB, aluSrcAB, extZeroB, illegalOpB;
    logic [2:0] aluOpB;
    logic [3:0] stateB;

    ctl_t obsA, obsB;
    assign obsA = {pcWriteA, pcWriteCondA, branchNeA, iorDA, irWriteA, memReadA, memWriteA,
                   memToRegA, regDestA, regWriteA, aluSrcAA, aluSrcBA, extZeroA, aluOpA,
                   pcSourceA, illegalOpA, stateA};
    assign obsB = {pcWriteB, pcWriteCondB, branchNeB, iorDB, irWriteB, memReadB, memWriteB,
                   memToRegB, regDestB, regWriteB, aluSrcAB, aluSrcBB, extZeroB, aluOpB,
                   pcSourceB, illegalOpB, stateB};

    multi_cycle_ctr #(.MEM_HANDSHAKE(1'b1), .ENABLE_IMM(1'b1), .ENABLE_JAL(1'b1)) dutA (
        .clk(clk), .reset_n(reset_n), .opCode(opCode), .memReady(memReady),
        .pcWrite(pcWriteA), .pcWriteCond(pcWriteCondA), .branchNe(branchNeA), .iorD(iorDA),
        .irWrite(irWriteA), .memRead(memReadA), .memWrite(memWriteA), .memToReg(memToRegA),
        .regDest(regDestA), .regWrite(regWriteA), .aluSrcA(aluSrcAA), .aluSrcB(aluSrcBA),
        .extZero(extZeroA), .ALUop(aluOpA), .pcSource(pcSourceA), .illegalOp(illegalOpA),
        .state(stateA)
    );

    multi_cycle_ctr #(.MEM_HANDSHAKE(1'b1), .ENABLE_IMM(1'b1), .ENABLE_JAL(1'b0)) dutB (
        .clk(clk), .reset_n(reset_n), .opCode(opCode), .memReady(memReady),
        .pcWrite(pcWriteB), .pcWriteCond(pcWriteCondB), .branchNe(branchNeB), .iorD(iorDB),
        .irWrite(irWriteB), .memRead(memReadB), .memWrite(memWriteB), .memToReg(memToRegB),
        .regDest(regDestB), .regWrite(regWriteB), .aluSrcA(aluSrcAB), .aluSrcB(aluSrcBB),
        .extZero(extZeroB), .ALUop(aluOpB), .pcSource(pcSourceB), .illegalOp(illegalOpB),
        .state(stateB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    ctl_t       expQ[$];
    ctl_t       expBQ[$];
    logic       rdyQ[$];
    logic [5:0] opQ[$];

    function automatic ctl_t blank(input logic [3:0] st);
        ctl_t c;
        c = '0;
        c.state = st;
        return c;
    endfunction

    function automatic ctl_t expFetch(input logic rdy);
        ctl_t c;
        c = blank(FETCH);
        c.memRead = 1'b1;
        c.aluSrcB = 2'b01;
        c.irWrite = rdy;
        c.pcWrite = rdy;
        return c;
    endfunction

    function automatic ctl_t expDecode();
        ctl_t c;
        c = blank(DECODE);
        c.aluSrcB = 2'b11;
        return c;
    endfunction

    // Queue one cycle: expected vector plus the inputs driven during that cycle
    task automatic push(input ctl_t e, input logic rdy, input logic [5:0] op);
        expQ.push_back(e);
        rdyQ.push_back(rdy);
        opQ.push_back(op);
    endtask

    task automatic test_reset();
        ctl_t e;
        reset_n  = 1'b0;
        opCode   = OP_LW;
        memReady = 1'b1;
        #12;
        e = blank(IDLE);
        checks++;
        if (obsA !== e) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obsA, e);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obsA !== e) begin
            errors++;
            $display("FAIL reset_idle_after_release: got %h expected %h", obsA, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        ctl_t e;
        int   n = 0;
        push(expFetch(1'b1), 1'b1, OP_LW);
        push(expDecode(), 1'b1, OP_LW);
        e = blank(MEM_ADDR); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
        push(e, 1'b1, OP_SW);
        e = blank(MEM_READ); e.memRead = 1'b1; e.iorD = 1'b1;
        push(e, 1'b1, OP_SW);
        e = blank(MEM_WB); e.memToReg = 2'b01; e.regWrite = 1'b1;
        push(e, 1'b1, OP_SW);
        while (expQ.size() != 0) begin
            memReady = rdyQ.pop_front();
            opCode   = opQ.pop_front();
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obsA !== e) begin
                errors++;
                $display("FAIL lw cyc%0d: got %h expected %h", n, obsA, e);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sw_wait();
        ctl_t e;
        int   n = 0;
        push(expFetch(1'b1), 1'b1, OP_SW);
        push(expDecode(), 1'b1, OP_SW);
        e = blank(MEM_ADDR); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
        push(e, 1'b1, OP_LW);
        e = blank(MEM_WRITE); e.memWrite = 1'b1; e.iorD = 1'b1;
        push(e, 1'b0, OP_LW);
        push(e, 1'b0, OP_RTYPE);
        push(e, 1'b0, OP_LW);
        push(e, 1'b1, OP_LW);
        while (expQ.size() != 0) begin
            memReady = rdyQ.pop_front();
            opCode   = opQ.pop_front();
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obsA !== e) begin
                errors++;
                $display("FAIL sw_wait cyc%0d: got %h expected %h", n, obsA, e);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        ctl_t e;
        int   n = 0;
        push(expFetch(1'b0), 1'b0, OP_BNE);
        push(expFetch(1'b1), 1'b1, OP_BNE);
        push(expDecode(), 1'b1, OP_BNE);
        e = blank(BRANCH); e.aluSrcA = 1'b1; e.aluOp = 3'b001; e.pcWriteCond = 1'b1;
        e.pcSource = 2'b01; e.branchNe = 1'b1;
        push(e, 1'b1, OP_BEQ);
        push(expFetch(1'b1), 1'b1, OP_BEQ);
        push(expDecode(), 1'b1, OP_BEQ);
        e.branchNe = 1'b0;
        push(e, 1'b1, OP_BNE);
        while (expQ.size() != 0) begin
            memReady = rdyQ.pop_front();
            opCode   = opQ.pop_front();
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obsA !== e) begin
                errors++;
                $display("FAIL branch cyc%0d: got %h expected %h", n, obsA, e);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jal();
        ctl_t e, eb;
        int   n = 0;
        push(expFetch(1'b1), 1'b1, OP_JAL);
        expBQ.push_back(expFetch(1'b1));
        push(expDecode(), 1'b1, OP_JAL);
        expBQ.push_back(expDecode());
        e = blank(JUMP); e.pcWrite = 1'b1; e.pcSource = 2'b10; e.regWrite = 1'b1;
        e.regDest = 2'b10; e.memToReg = 2'b10;
        push(e, 1'b1, OP_LW);
        e = blank(ILLEGAL); e.illegalOp = 1'b1;
        expBQ.push_back(e);
        // Both instances must be back in FETCH, illegal pulse gone
        push(expFetch(1'b1), 1'b1, OP_J);
        expBQ.push_back(expFetch(1'b1));
        push(expDecode(), 1'b1, OP_J);
        expBQ.push_back(expDecode());
        e = blank(JUMP); e.pcWrite = 1'b1; e.pcSource = 2'b10;
        push(e, 1'b1, OP_J);
        expBQ.push_back(e);
        while (expQ.size() != 0) begin
            memReady = rdyQ.pop_front();
            opCode   = opQ.pop_front();
            @(negedge clk);
            e  = expQ.pop_front();
            eb = expBQ.pop_front();
            checks++;
            if (obsA !== e) begin
                errors++;
                $display("FAIL jal cyc%0d: got %h expected %h", n, obsA, e);
            end
            checks++;
            if (obsB !== eb) begin
                errors++;
                $display("FAIL jal_disabled cyc%0d: got %h expected %h", n, obsB, eb);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_imm_illegal();
        ctl_t e;
        int   n = 0;
        push(expFetch(1'b1), 1'b1, OP_ORI);
        push(expDecode(), 1'b1, OP_ORI);
        e = blank(I_EXEC); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'b100;
        e.extZero = 1'b1;
        push(e, 1'b1, OP_SLTI);
        e = blank(I_WB); e.aluOp = 3'b100; e.extZero = 1'b1; e.regWrite = 1'b1;
        push(e, 1'b1, 6'b010101);
        push(expFetch(1'b1), 1'b1, 6'b010101);
        push(expDecode(), 1'b1, 6'b010101);
        e = blank(ILLEGAL); e.illegalOp = 1'b1;
        push(e, 1'b1, OP_SLTI);
        push(expFetch(1'b1), 1'b1, OP_SLTI);
        push(expDecode(), 1'b1, OP_SLTI);
        e = blank(I_EXEC); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'b101;
        push(e, 1'b1, OP_ANDI);
        e = blank(I_WB); e.aluOp = 3'b101; e.regWrite = 1'b1;
        push(e, 1'b1, OP_ANDI);
        while (expQ.size() != 0) begin
            memReady = rdyQ.pop_front();
            opCode   = opQ.pop_front();
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obsA !== e) begin
                errors++;
                $display("FAIL imm_illegal cyc%0d: got %h expected %h", n, obsA, e);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        ctl_t e;
        int   n = 0;
        push(expFetch(1'b1), 1'b1, OP_RTYPE);
        push(expDecode(), 1'b1, OP_RTYPE);
        e = blank(R_EXEC); e.aluSrcA = 1'b1; e.aluOp = 3'b010;
        push(e, 1'b1, OP_LW);
        e = blank(R_WB); e.regDest = 2'b01; e.regWrite = 1'b1;
        push(e, 1'b1, OP_LW);
        push(expFetch(1'b1), 1'b1, OP_ADDI);
        push(expDecode(), 1'b1, OP_ADDI);
        e = blank(I_EXEC); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
        push(e, 1'b1, OP_RTYPE);
        e = blank(I_WB); e.regWrite = 1'b1;
        push(e, 1'b1, OP_RTYPE);
        while (expQ.size() != 0) begin
            memReady = rdyQ.pop_front();
            opCode   = opQ.pop_front();
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obsA !== e) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %h expected %h", n, obsA, e);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        ctl_t e;
        int   n = 0;
        push(expFetch(1'b1), 1'b1, OP_LW);
        push(expDecode(), 1'b1, OP_LW);
        e = blank(MEM_ADDR); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
        push(e, 1'b0, OP_LW);
        e = blank(MEM_READ); e.memRead = 1'b1; e.iorD = 1'b1;
        push(e, 1'b0, OP_LW);
        while (expQ.size() != 0) begin
            memReady = rdyQ.pop_front();
            opCode   = opQ.pop_front();
            @(negedge clk);
            e = expQ.pop_front();
            checks++;
            if (obsA !== e) begin
                errors++;
                $display("FAIL reset_mid cyc%0d: got %h expected %h", n, obsA, e);
            end
            n++;
            if (expQ.size() != 0) begin
                @(posedge clk);
                #1;
            end
        end
        // Still in MEM_READ, mid-cycle: reset must take effect without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        e = blank(IDLE);
        checks++;
        if (obsA !== e) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", obsA, e);
        end
        @(posedge clk);
        #1;
        memReady = 1'b1;
        reset_n  = 1'b1;
        @(negedge clk);
        checks++;
        if (obsA !== e) begin
            errors++;
            $display("FAIL reset_mid_idle: got %h expected %h", obsA, e);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        e = expFetch(1'b1);
        checks++;
        if (obsA !== e) begin
            errors++;
            $display("FAIL reset_mid_fetch: got %h expected %h", obsA, e);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jal();
        test_imm_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctr.md
Name: multi_cycle_ctr

Overview:
Multi-cycle MIPS main control unit, the successor to the single-cycle Ctr decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath enables per cycle. It extends the instruction set with bne, jal and immediate ALU ops, and adds an optional memory ready handshake. It sits between the instruction register (opCode) and the multi-cycle datapath/memory port.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH/MEM_READ/MEM_WRITE wait for memReady; 0 = memReady ignored, treated as 1
ENABLE_IMM, 1, 1 = addi/andi/ori/slti decoded; 0 = they go to ILLEGAL
ENABLE_JAL, 1, 1 = jal decoded; 0 = jal goes to ILLEGAL

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
opCode  in  6  instr[31:26] from IR, sampled in DECODE
memReady  in  1  memory completes the current access this cycle
pcWrite  out  1  unconditional PC load
pcWriteCond  out  1  conditional PC load (branch)
branchNe  out  1  1 = take branch on ALU not-zero (bne), 0 = on zero
iorD  out  1  memory address: 0 = PC, 1 = ALUOut
irWrite  out  1  IR load
memRead  out  1  memory read request
memWrite  out  1  memory write request
memToReg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC (jal)
regDest  out  2  write reg: 00 rt, 01 rd, 10 $31
regWrite  out  1  register file write
aluSrcA  out  1  0 = PC, 1 = rs
aluSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
extZero  out  1  1 = zero-extend imm (andi/ori)
ALUop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
pcSource  out  2  00 ALU, 01 ALUOut, 10 jump target
illegalOp  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state, for debug

Behaviour:
- Registered state, Moore outputs decoded from state and latched opcode (opReg). Every output not listed for a state is 0.
- Async reset: state=IDLE, opReg=0. All outputs are 0 in IDLE. IDLE->FETCH on the first clock edge after reset_n goes high.
- FETCH: memRead=1, aluSrcB=01, ALUop=add. When memReady=1: irWrite=1, pcWrite=1, go to DECODE. Otherwise hold, with irWrite=pcWrite=0.
- DECODE: opReg<=opCode, aluSrcB=11, ALUop=add. Next state by opCode:
  - 000000 -> R_EXEC
  - 100011/101011 -> MEM_ADDR
  - 000100/000101 -> BRANCH
  - 000010/000011 -> JUMP (000011 only if ENABLE_JAL)
  - 001000/001100/001101/001010 -> I_EXEC (if ENABLE_IMM)
  - anything else -> ILLEGAL
- MEM_ADDR: aluSrcA=1, aluSrcB=10, add. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: memRead=1, iorD=1. Waits for memReady, then MEM_WB.
- MEM_WB: memToReg=01, regDest=00, regWrite=1, then FETCH.
- MEM_WRITE: memWrite=1, iorD=1. Waits for memReady, then FETCH.
- R_EXEC: aluSrcA=1, aluSrcB=00, ALUop=funct, then R_WB.
- R_WB: regDest=01, regWrite=1, then FETCH.
- BRANCH: aluSrcA=1, ALUop=sub, pcWriteCond=1, pcSource=01, branchNe=(opReg==000101), then FETCH.
- JUMP: pcWrite=1, pcSource=10. For jal also regWrite=1, regDest=10, memToReg=10. Then FETCH.
- I_EXEC: aluSrcA=1, aluSrcB=10. ALUop: addi=add, andi=and, ori=or, slti=slt. extZero=1 for andi/ori. Then I_WB.
- I_WB: ALUop and extZero held from I_EXEC, regDest=00, regWrite=1, then FETCH.
- ILLEGAL: illegalOp=1 for exactly one cycle, no writes, then FETCH.
- Cycle counts with memReady=1: lw 5, sw 4, R 4, imm 4, beq/bne 3, j/jal 3.
- Each cycle memReady is low in a wait state adds one cycle. Outputs are stable during the wait.
- A change on opCode outside DECODE has no effect.
- reset_n asserted mid-instruction: immediate return to IDLE with all outputs 0. No partial write completes after that edge.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - ALUop codes
  - state encoding enum (IDLE=0 ... ILLEGAL)
  - mux select constants
- No sub-module. A single always_ff for state/opReg and a single always_comb for next-state and outputs.

Test Plan:
- Reset then release, opCode=100011, memReady=1: states IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH. regWrite=1 and memToReg=01 only in MEM_WB.
- opCode=101011 with memReady low for 3 cycles in MEM_WRITE: memWrite=1 and iorD=1 held 4 cycles, no regWrite, then FETCH.
- opCode=000101: BRANCH asserts pcWriteCond=1, branchNe=1, ALUop=001, pcSource=01. With opCode=000100, branchNe=0.
- opCode=000011: JUMP asserts pcWrite=1, pcSource=10, regWrite=1, regDest=10, memToReg=10. Rerun with ENABLE_JAL=0: illegalOp pulses 1 cycle, no writes.
- opCode=001101: I_EXEC then I_WB with ALUop=100, extZero=1, aluSrcB=10, regWrite=1 only in I_WB. opCode=010101: illegalOp=1 for one cycle, then FETCH.
- reset_n pulled low during MEM_READ: all outputs 0 asynchronously. After release, one IDLE cycle then FETCH with memRead=1.
